// File: rtl/memory_sub_system_pkg.sv
// Shared widths, derived address-field sizes and the cache controller state type
// for the memory sub-system blocks.
package memory_sub_system;

    localparam int ADDR_LENGTH = 16;
    localparam int DATA_WIDTH  = 32;
    localparam int INDEX_BITS  = 6;
    localparam int OFFSET_BITS = 2;
    localparam int TAG_BITS    = ADDR_LENGTH - INDEX_BITS - OFFSET_BITS;
    localparam int NUM_LINES   = 1 << INDEX_BITS;
    localparam int LINE_WORDS  = 1 << OFFSET_BITS;

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        WRITEBACK,
        ALLOCATE
    } cache_state_t;

endpackage

// File: rtl/dm_cache_array.sv
// Tag, valid, dirty and data storage for the direct-mapped cache.
// Writes land on the rising edge; all reads are combinational on the selected line.
module dm_cache_array
    import memory_sub_system::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INDEX_BITS-1:0]  index,
    input  logic [OFFSET_BITS-1:0] rd_offset,
    output logic                   valid,
    output logic                   dirty,
    output logic [TAG_BITS-1:0]    tag,
    output logic [DATA_WIDTH-1:0]  rd_word,
    input  logic                   wr_en,
    input  logic [OFFSET_BITS-1:0] wr_offset,
    input  logic [DATA_WIDTH-1:0]  wr_word,
    input  logic                   set_dirty,
    input  logic                   fill_done,
    input  logic [TAG_BITS-1:0]    fill_tag
);

    logic [NUM_LINES-1:0]  valid_q;
    logic [NUM_LINES-1:0]  dirty_q;
    logic [TAG_BITS-1:0]   tag_q  [NUM_LINES];
    logic [DATA_WIDTH-1:0] data_q [NUM_LINES][LINE_WORDS];

    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            if (set_dirty) dirty_q[index] <= 1'b1;
            if (fill_done) begin
                valid_q[index] <= 1'b1;
                dirty_q[index] <= 1'b0;
            end
        end
    end

    // NOTE: tag and data arrays are deliberately not reset; the cleared valid bits hide stale contents.
    always_ff @(posedge clk) begin
        if (!rst && wr_en)     data_q[index][wr_offset] <= wr_word;
        if (!rst && fill_done) tag_q[index]             <= fill_tag;
    end

    assign valid   = valid_q[index];
    assign dirty   = dirty_q[index];
    assign tag     = tag_q[index];
    assign rd_word = data_q[index][rd_offset];

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-back, write-allocate cache controller: answers CPU word requests
// and moves whole lines to/from word-wide memory with a req/ack handshake.
module dm_cache_ctrl
    import memory_sub_system::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cpu_req,
    input  logic                   cpu_we,
    input  logic [ADDR_LENGTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0]  cpu_wdata,
    output logic [DATA_WIDTH-1:0]  cpu_rdata,
    output logic                   cpu_ack,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [ADDR_LENGTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]  mem_wdata,
    input  logic [DATA_WIDTH-1:0]  mem_rdata,
    input  logic                   mem_ack
);

    cache_state_t state, state_next;

    logic [ADDR_LENGTH-1:0] req_addr;
    logic                   req_we;
    logic [DATA_WIDTH-1:0]  req_wdata;
    logic [TAG_BITS-1:0]    req_tag;
    logic [INDEX_BITS-1:0]  req_index;
    logic [OFFSET_BITS-1:0] req_offset;
    logic [OFFSET_BITS-1:0] cnt;

    logic                   line_valid, line_dirty, hit;
    logic [TAG_BITS-1:0]    line_tag;
    logic [DATA_WIDTH-1:0]  line_word;
    logic [OFFSET_BITS-1:0] rd_offset, wr_offset;
    logic [DATA_WIDTH-1:0]  wr_word;
    logic                   wr_en, set_dirty, fill_done;
    logic                   xfer_done, last_word;

    assign {req_tag, req_index, req_offset} = req_addr;
    assign hit       = line_valid && (line_tag == req_tag);
    // An ack only counts while a request is actually outstanding.
    assign xfer_done = mem_req && mem_ack;
    assign last_word = &cnt;

    dm_cache_array u_array (
        .clk       (clk),
        .rst       (rst),
        .index     (req_index),
        .rd_offset (rd_offset),
        .valid     (line_valid),
        .dirty     (line_dirty),
        .tag       (line_tag),
        .rd_word   (line_word),
        .wr_en     (wr_en),
        .wr_offset (wr_offset),
        .wr_word   (wr_word),
        .set_dirty (set_dirty),
        .fill_done (fill_done),
        .fill_tag  (req_tag)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        cpu_ack    = 1'b0;
        cpu_rdata  = '0;
        rd_offset  = req_offset;
        wr_en      = 1'b0;
        wr_offset  = req_offset;
        wr_word    = req_wdata;
        set_dirty  = 1'b0;
        fill_done  = 1'b0;
        unique case (state)
            IDLE: begin
                if (cpu_req) state_next = COMPARE;
            end
            COMPARE: begin
                if (hit) begin
                    cpu_ack    = !rst;
                    cpu_rdata  = rst ? '0 : line_word;
                    wr_en      = req_we;
                    set_dirty  = req_we;
                    state_next = IDLE;
                end else if (line_valid && line_dirty) begin
                    state_next = WRITEBACK;
                end else begin
                    state_next = ALLOCATE;
                end
            end
            WRITEBACK: begin
                rd_offset = cnt;
                if (xfer_done && last_word) state_next = ALLOCATE;
            end
            ALLOCATE: begin
                wr_offset = cnt;
                wr_word   = mem_rdata;
                wr_en     = xfer_done;
                if (xfer_done && last_word) begin
                    fill_done  = 1'b1;
                    state_next = COMPARE;
                end
            end
        endcase
    end

    // Request capture and the word-by-word memory handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_addr  <= '0;
            req_we    <= 1'b0;
            req_wdata <= '0;
            cnt       <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            if (state == IDLE && cpu_req) begin
                req_addr  <= cpu_addr;
                req_we    <= cpu_we;
                req_wdata <= cpu_wdata;
            end
            if (state == COMPARE) cnt <= '0;
            if (state == WRITEBACK || state == ALLOCATE) begin
                if (xfer_done) begin
                    // Dropping mem_req here guarantees an idle cycle between words.
                    mem_req <= 1'b0;
                    cnt     <= cnt + 1'b1;
                end else if (!mem_req) begin
                    mem_req   <= 1'b1;
                    mem_we    <= (state == WRITEBACK);
                    mem_addr  <= {(state == WRITEBACK) ? line_tag : req_tag, req_index, cnt};
                    mem_wdata <= line_word;
                end
            end
        end
    end

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Self-checking bench for dm_cache_ctrl: a line-level cache model plus a coherent memory
// image predict every memory transaction and every CPU read; a random-latency memory responds.
module tb_dm_cache_ctrl;
    import memory_sub_system::*;

    logic                   clk       = 1'b0;
    logic                   rst       = 1'b1;
    logic                   cpu_req   = 1'b0;
    logic                   cpu_we    = 1'b0;
    logic [ADDR_LENGTH-1:0] cpu_addr  = '0;
    logic [DATA_WIDTH-1:0]  cpu_wdata = '0;
    logic [DATA_WIDTH-1:0]  cpu_rdata;
    logic                   cpu_ack;
    logic                   mem_req;
    logic                   mem_we;
    logic [ADDR_LENGTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0]  mem_wdata;
    logic [DATA_WIDTH-1:0]  mem_rdata = '0;
    logic                   mem_ack   = 1'b0;

    always #5 clk = ~clk;

    dm_cache_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ack   (cpu_ack),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [31:0] data;
    } mem_txn_t;

    int checks = 0;
    int errors = 0;

    logic [31:0] phys [0:65535];   // contents of main memory
    logic [31:0] coh  [0:65535];   // value the CPU must observe at each address
    logic        m_valid [0:63];
    logic        m_dirty [0:63];
    logic [7:0]  m_tag   [0:63];
    mem_txn_t    exp_q[$];
    logic [16:0] seen_q[$];
    logic [31:0] last_rdata = '0;
    bit          prev_hold  = 1'b0;
    localparam int BUDGET = 400;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic finish_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    function automatic logic [31:0] init_val(input logic [15:0] a);
        return {a, ~a};
    endfunction

    // Memory responder plus per-cycle handshake checks.
    logic        p_rst = 1'b1, p_req = 1'b0, p_acc = 1'b0, p_cpu_ack = 1'b0, p_we = 1'b0;
    logic [15:0] p_addr  = '0;
    logic [31:0] p_wdata = '0;
    bit          pending = 1'b0;
    int unsigned delay   = 0;
    mem_txn_t    t;

    always @(negedge clk) begin
        if (!rst && !p_rst) begin
            if (p_acc)
                check("mem_req_low_after_ack", 64'(mem_req), 64'd0);
            else if (p_req)
                check("mem_req_held_stable", 64'({mem_req, mem_we, mem_addr, mem_wdata}),
                      64'({1'b1, p_we, p_addr, p_wdata}));
            if (p_cpu_ack) check("cpu_ack_one_cycle", 64'(cpu_ack), 64'd0);
        end
        mem_ack = 1'b0;
        if (rst) begin
            pending = 1'b0;
        end else if (mem_req) begin
            if (!pending) begin
                pending = 1'b1;
                delay   = $urandom_range(0, 5);
            end
            if (delay == 0) begin
                pending = 1'b0;
                mem_ack = 1'b1;
                seen_q.push_back({mem_we, mem_addr});
                check("mem_txn_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    t = exp_q.pop_front();
                    check("mem_txn_dir_addr", 64'({mem_we, mem_addr}), 64'({t.we, t.addr}));
                    if (t.we) check("mem_writeback_data", 64'(mem_wdata), 64'(t.data));
                end
                if (mem_we) phys[mem_addr] = mem_wdata;
                else        mem_rdata      = phys[mem_addr];
            end else begin
                delay--;
            end
        end else if ($urandom_range(0, 2) == 0) begin
            mem_ack   = 1'b1;          // spurious ack, must be ignored
            mem_rdata = $urandom;
        end
        p_rst     = rst;
        p_req     = mem_req;
        p_acc     = mem_req && mem_ack;
        p_cpu_ack = cpu_ack;
        p_we      = mem_we;
        p_addr    = mem_addr;
        p_wdata   = mem_wdata;
    end

    // Predict the memory traffic of one access and advance the model.
    task automatic plan(input logic [15:0] a, input logic we, input logic [31:0] wd,
                        output bit hit, output logic [31:0] rd);
        logic [5:0]  idx;
        logic [7:0]  tg;
        logic [15:0] wa;
        idx = a[7:2];
        tg  = a[15:8];
        hit = m_valid[idx] && (m_tag[idx] == tg);
        if (!hit) begin
            if (m_valid[idx] && m_dirty[idx])
                for (int k = 0; k < 4; k++) begin
                    wa = {m_tag[idx], idx, 2'(k)};
                    exp_q.push_back(mem_txn_t'{1'b1, wa, coh[wa]});
                end
            for (int k = 0; k < 4; k++)
                exp_q.push_back(mem_txn_t'{1'b0, {tg, idx, 2'(k)}, 32'd0});
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
            m_dirty[idx] = 1'b0;
        end
        rd = coh[a];
        if (we) begin
            coh[a]       = wd;
            m_dirty[idx] = 1'b1;
        end
    endtask

    task automatic do_access(input logic [15:0] a, input logic we, input logic [31:0] wd, input bit hold);
        bit          hit;
        logic [31:0] exp_rd;
        int          n;
        plan(a, we, wd, hit, exp_rd);
        cpu_req   = 1'b1;
        cpu_addr  = a;
        cpu_we    = we;
        cpu_wdata = wd;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cpu_ack && n < BUDGET);
        check("cpu_ack_within_budget", 64'(cpu_ack), 64'd1);
        if (!cpu_ack) finish_run();
        last_rdata = cpu_rdata;
        if (hit) check("hit_latency", 64'(n), prev_hold ? 64'd2 : 64'd1);
        if (!we) check("read_data", 64'(cpu_rdata), 64'(exp_rd));
        check("mem_txns_consumed", 64'(exp_q.size()), 64'd0);
        prev_hold = hold;
        if (!hold) begin
            cpu_req  = 1'b0;
            cpu_addr = 16'($urandom);
            @(negedge clk);
        end
    endtask

    // Reset lasts two negedges; outputs are checked one cycle after it is raised.
    task automatic apply_reset();
        rst     = 1'b1;
        cpu_req = 1'b0;
        @(negedge clk);
        check("rst_cpu_ack",   64'(cpu_ack),   64'd0);
        check("rst_cpu_rdata", 64'(cpu_rdata), 64'd0);
        check("rst_mem_req",   64'(mem_req),   64'd0);
        check("rst_mem_we",    64'(mem_we),    64'd0);
        check("rst_mem_addr",  64'(mem_addr),  64'd0);
        check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        @(negedge clk);
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        for (int i = 0; i < 65536; i++) coh[i] = phys[i];
        exp_q.delete();
        prev_hold = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        bit          h;
        logic [31:0] rd;
        logic [7:0]  tags [4];
        int          n;
        for (int i = 0; i < 65536; i++) phys[i] = init_val(16'(i));
        apply_reset();

        // Cold read miss fetches the whole line.
        seen_q.delete();
        do_access(16'h1234, 1'b0, 32'd0, 1'b0);
        check("cold_read_literal", 64'(last_rdata), 64'h1234EDCB);
        check("cold_fill_count", 64'(seen_q.size()), 64'd4);
        for (int i = 0; i < 4 && i < seen_q.size(); i++)
            check("cold_fill_addr", 64'(seen_q[i]), 64'({1'b0, 16'h1234 + 16'(i)}));

        // Hit, write hit, then a conflicting read forcing write-back.
        do_access(16'h1235, 1'b0, 32'd0, 1'b0);
        check("hit_read_literal", 64'(last_rdata), 64'h1235EDCA);
        do_access(16'h1236, 1'b1, 32'hDEADBEEF, 1'b0);
        seen_q.delete();
        do_access(16'h5236, 1'b0, 32'd0, 1'b0);
        check("wb_alloc_count", 64'(seen_q.size()), 64'd8);
        for (int i = 0; i < 8 && i < seen_q.size(); i++)
            check("wb_alloc_order", 64'(seen_q[i]),
                  64'(i < 4 ? {1'b1, 16'h1234 + 16'(i)} : {1'b0, 16'h5230 + 16'(i)}));
        check("writeback_literal", 64'(phys[16'h1236]), 64'hDEADBEEF);

        // Back-to-back hits with cpu_req held high.
        do_access(16'h5234, 1'b0, 32'd0, 1'b1);
        do_access(16'h5235, 1'b0, 32'd0, 1'b1);
        do_access(16'h5237, 1'b0, 32'd0, 1'b1);
        do_access(16'h5236, 1'b0, 32'd0, 1'b0);

        // Reset while the second fill word is outstanding.
        plan(16'h7A10, 1'b0, 32'd0, h, rd);
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 16'h7A10;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(mem_req && mem_addr == 16'h7A11) && n < BUDGET);
        check("second_fill_word_reached", 64'(mem_req && mem_addr == 16'h7A11), 64'd1);
        if (n >= BUDGET) finish_run();
        apply_reset();
        seen_q.delete();
        do_access(16'h7A10, 1'b0, 32'd0, 1'b0);
        check("refetch_literal", 64'(last_rdata), 64'h7A1085EF);
        check("refetch_count", 64'(seen_q.size()), 64'd4);
        do_access(16'h1236, 1'b0, 32'd0, 1'b0);
        check("post_reset_writeback_kept", 64'(last_rdata), 64'hDEADBEEF);

        // Random mix over a few conflicting tags.
        tags = '{8'h12, 8'h52, 8'h7A, 8'hC3};
        for (int i = 0; i < 400; i++)
            do_access({tags[$urandom_range(0, 3)], 6'($urandom_range(0, 7)), 2'($urandom_range(0, 3))},
                      1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3) == 0);
        if (prev_hold) begin
            cpu_req = 1'b0;
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        finish_run();
    end

endmodule

// File: doc/dm_cache_ctrl.md
DM_CACHE_CTRL -- requirements
Module: dm_cache_ctrl

Interface
REQ-001 ADDR_LENGTH, 16, CPU/memory word-address width.
REQ-002 DATA_WIDTH, 32, data word width.
REQ-003 INDEX_BITS, 6, line index width (64 lines).
REQ-004 OFFSET_BITS, 2, word-in-line width (4 words/line); TAG = ADDR_LENGTH-INDEX_BITS-OFFSET_BITS (8).
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 cpu_req  in  1  CPU request; held high with cpu_addr/cpu_we/cpu_wdata stable until cpu_ack.
REQ-008 cpu_we  in  1  1=write, 0=read.
REQ-009 cpu_addr  in  ADDR_LENGTH  word address.
REQ-010 cpu_wdata  in  DATA_WIDTH  write data.
REQ-011 cpu_rdata  out  DATA_WIDTH  read data, valid only while cpu_ack=1.
REQ-012 cpu_ack  out  1  one-cycle completion pulse.
REQ-013 mem_req  out  1  memory word request, held until mem_ack.
REQ-014 mem_we  out  1  1=write-back word, 0=fill word.
REQ-015 mem_addr  out  ADDR_LENGTH  memory word address.
REQ-016 mem_wdata  out  DATA_WIDTH  write-back data.
REQ-017 mem_rdata  in  DATA_WIDTH  fill data, valid with mem_ack.
REQ-018 mem_ack  in  1  one-cycle memory completion pulse.

Function
REQ-019 Block SHALL be the cache (responder) end of the CPU-cache interface: direct-mapped, write-back, write-allocate.
REQ-020 FSM states SHALL be IDLE, COMPARE, WRITEBACK, ALLOCATE.
REQ-021 IDLE: cpu_req=1 SHALL latch addr/we/wdata and go to COMPARE next cycle.
REQ-022 COMPARE hit (valid & tag match): cpu_ack=1 that cycle, cpu_rdata=line word; write updates word and sets dirty; next state IDLE. Hit latency = 1 cycle after request sampled.
REQ-023 COMPARE miss, line clean or invalid: go to ALLOCATE; miss, valid & dirty: go to WRITEBACK.
REQ-024 WRITEBACK SHALL issue 4 writes, mem_addr={old tag, index, cnt}, cnt 0..3, advancing on each mem_ack; after 4th ack go to ALLOCATE.
REQ-025 ALLOCATE SHALL issue 4 reads, mem_addr={new tag, index, cnt}, storing mem_rdata on each mem_ack; after 4th ack set valid, clear dirty, write tag, return to COMPARE (guaranteed hit).
REQ-026 mem_req SHALL deassert for at least the cycle after each mem_ack; mem_addr/mem_we/mem_wdata stable while mem_req=1.
REQ-027 mem_ack while mem_req=0 SHALL be ignored.
REQ-028 Word counter SHALL be OFFSET_BITS wide, wrap 3->0, and reset to 0 on entry to WRITEBACK/ALLOCATE.
REQ-029 Back-to-back: cpu_req high in the IDLE cycle after cpu_ack SHALL be accepted as a new request.
REQ-030 cpu_ack SHALL never be asserted outside COMPARE; cpu_req changes while not IDLE SHALL be ignored.

Reset
REQ-031 rst SHALL force IDLE, clear all valid and dirty bits, counter 0, cpu_ack=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rdata=0.
REQ-032 rst mid-WRITEBACK/ALLOCATE SHALL abort the transfer immediately; no ack issued; data array contents need not be cleared.

Structure
REQ-033 ADDR_LENGTH/DATA_WIDTH defaults, state enum, and tag/index/offset field-width constants SHALL live in the shared memory_sub_system package.
REQ-034 Tag/valid/dirty/data storage SHALL be one sub-module, dm_cache_array (synchronous write, combinational read).

Verification
REQ-035 After reset, read 0x1234 -> ALLOCATE fetches 0x1234..0x1237 (mem_we=0), then cpu_ack with mem word 0x1234 data.
REQ-036 Read 0x1235 after REQ-035 -> cpu_ack exactly 1 cycle after request sampled, no mem_req.
REQ-037 Write 0xDEADBEEF to 0x1236 (hit), then read 0x5236 (same index, tag 0x52) -> WRITEBACK writes 0x1234..0x1237 incl. 0xDEADBEEF at 0x1236, then ALLOCATE 0x5234..0x5237.
REQ-038 Memory acks with 0-5 cycle random delay plus spurious mem_ack while mem_req=0 -> identical results, no extra counter advance.
REQ-039 Assert rst during 2nd ALLOCATE word -> outputs at reset values next cycle; subsequent read of same address misses and refetches.
REQ-040 cpu_req held continuously for 4 hitting addresses -> 4 cpu_ack pulses, one per 2 cycles, correct data each.
